nibble_serial_adder_ctrl: RTL and testbench

- Sequences a shared 4-bit adder slice over a WIDTH-bit operand pair, one nibble per clock, with the carry held in a flop between nibbles.
- Replaces a full-width parallel adder where area matters more than latency.
- Upstream and downstream each use a valid/ready handshake.
- Owns the operand registers, the nibble index counter, the carry flop and the result register.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 22 ++
 rtl/nibble_serial_adder_ctrl_nibble_add.sv | 14 +
 rtl/nibble_serial_adder_ctrl.sv | 122 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder controller.
`timescale 1ns/1ps

package nibble_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Number of 4-bit slices in a WIDTH-bit operand.
    function automatic int unsigned nibbles(input int unsigned width);
        return width / 4;
    endfunction

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_nibble_add.sv
// Combinational 4-bit slice adder: a + b + carry-in -> 4-bit sum, carry-out.
`timescale 1ns/1ps

module nibble_serial_adder_ctrl_nibble_add (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic       c_o
);

    assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequences one shared 4-bit adder slice across a WIDTH-bit operand pair,
// one nibble per clock, with the inter-nibble carry held in a flop.
`timescale 1ns/1ps

module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic             CarryIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Busy
);

    localparam int unsigned Nibbles = nibbles(WIDTH);
    localparam int unsigned IdxW    = idx_width(Nibbles);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Nibbles - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              cout_q, cout_d;
    logic              carry_q, carry_d;
    logic [IdxW-1:0]   idx_q, idx_d;

    logic [3:0]        a_nib, b_nib, sum_nib;
    logic              c_nib;

    // Nibble select: the slice of each operand addressed by the index counter.
    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4];

    nibble_serial_adder_ctrl_nibble_add u_nibble_add (
        .a_i   (a_nib),
        .b_i   (b_nib),
        .c_i   (carry_q),
        .sum_o (sum_nib),
        .c_o   (c_nib)
    );

    // Next-state: accept in idle, one slice per clock in run, hold in done.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (InValid) begin
                    a_d     = DataA;
                    b_d     = DataB;
                    carry_d = CarryIn;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d[{idx_q, 2'b00} +: 4] = sum_nib;
                carry_d = c_nib;
                if (idx_q == LastIdx) begin
                    cout_d  = c_nib;
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (OutReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs decoded from registered state only.
    assign InReady  = (state_q == StIdle);
    assign OutValid = (state_q == StDone);
    assign Busy     = (state_q != StIdle);
    assign Result   = res_q;
    assign Cout     = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=64 and WIDTH=4).
`timescale 1ns/1ps

module tb_nibble_serial_adder_ctrl;

    logic        Clock;
    logic        ResetN;

    logic        in_valid, in_ready, carry_in, out_valid, out_ready, cout, busy;
    logic [63:0] data_a, data_b, result;

    logic        v4, r4_in_ready, cin4, ov4, or4, c4, busy4;
    logic [3:0]  a4, b4, res4;

    int checks = 0;
    int passed = 0;

    nibble_serial_adder_ctrl #(.WIDTH(64)) dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .DataA    (data_a),
        .DataB    (data_b),
        .CarryIn  (carry_in),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .Result   (result),
        .Cout     (cout),
        .Busy     (busy)
    );

    nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .InValid  (v4),
        .InReady  (r4_in_ready),
        .DataA    (a4),
        .DataB    (b4),
        .CarryIn  (cin4),
        .OutValid (ov4),
        .OutReady (or4),
        .Result   (res4),
        .Cout     (c4),
        .Busy     (busy4)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: plain (WIDTH+1)-bit unsigned sum.
    function automatic logic [64:0] ref_sum(input logic [63:0] a, input logic [63:0] b,
                                            input logic c);
        return {1'b0, a} + {1'b0, b} + {64'd0, c};
    endfunction

    // Accept one operand pair, then count edges until OutValid (bounded).
    task automatic run_op64(input logic [63:0] a, input logic [63:0] b, input logic c,
                            output int lat);
        data_a   = a;
        data_b   = b;
        carry_in = c;
        in_valid = 1'b1;
        @(posedge Clock); #1;
        in_valid = 1'b0;
        data_a   = {$urandom, $urandom};
        data_b   = {$urandom, $urandom};
        carry_in = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge Clock); #1;
            lat++;
        end
    endtask

    task automatic finish_op64();
        out_ready = 1'b1;
        @(posedge Clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_ctrl: ready/valid/busy=%b%b%b need 100",
                     in_ready, out_valid, busy);
        else passed++;
        checks++;
        if (result !== 64'd0 || cout !== 1'b0)
            $display("FAIL reset_data: result=%h cout=%b need 0/0", result, cout);
        else passed++;
        @(negedge Clock);
        ResetN = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_full_carry();
        int lat;
        run_op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
        checks++;
        if (lat !== 16) $display("FAIL full_carry_latency: got %0d need 16", lat);
        else passed++;
        checks++;
        if (result !== 64'd0 || cout !== 1'b1)
            $display("FAIL full_carry_sum: result=%h cout=%b need 0/1", result, cout);
        else passed++;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL full_carry_done_flags: busy=%b in_ready=%b need 1/0", busy, in_ready);
        else passed++;
        finish_op64();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL full_carry_release: out_valid=%b in_ready=%b need 0/1",
                     out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_carry_chain();
        logic [63:0] a, b;
        logic [64:0] exp;
        a   = 64'h0123_4567_89AB_CDEF;
        b   = 64'hFEDC_BA98_7654_3210;
        exp = ref_sum(a, b, 1'b1);
        data_a   = a;
        data_b   = b;
        carry_in = 1'b1;
        in_valid = 1'b1;
        @(posedge Clock); #1;
        in_valid = 1'b0;
        data_a   = '0;
        data_b   = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge Clock); #1;
            checks++;
            if (result[4*i +: 4] !== exp[4*i +: 4])
                $display("FAIL chain_nibble%0d: got %h need %h", i, result[4*i +: 4],
                         exp[4*i +: 4]);
            else passed++;
            checks++;
            if (out_valid !== (i == 15))
                $display("FAIL chain_valid_e%0d: got %b need %b", i + 1, out_valid, (i == 15));
            else passed++;
        end
        checks++;
        if ({cout, result} !== exp)
            $display("FAIL chain_final: got %b_%h need %h", cout, result, exp);
        else passed++;
        finish_op64();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op64(64'd5, 64'd3, 1'b0, lat);
        checks++;
        if (lat !== 16) $display("FAIL bp_latency: got %0d need 16", lat);
        else passed++;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            data_a   = {$urandom, $urandom};
            data_b   = {$urandom, $urandom};
            @(posedge Clock); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 64'd8 || cout !== 1'b0)
                $display("FAIL bp_hold%0d: valid=%b ready=%b result=%h cout=%b need 1/0/8/0",
                         k, out_valid, in_ready, result, cout);
            else passed++;
        end
        in_valid = 1'b0;
        finish_op64();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL bp_release: in_ready=%b busy=%b need 1/0", in_ready, busy);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        data_a   = {$urandom, $urandom};
        data_b   = {$urandom, $urandom};
        carry_in = 1'b1;
        in_valid = 1'b1;
        @(posedge Clock); #1;
        in_valid = 1'b0;
        repeat (8) begin
            @(posedge Clock); #1;
        end
        checks++;
        if (busy !== 1'b1) $display("FAIL midrun_busy: got %b need 1", busy);
        else passed++;
        ResetN = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== 64'd0)
            $display("FAIL midrun_async_reset: valid=%b busy=%b ready=%b result=%h need 0/0/1/0",
                     out_valid, busy, in_ready, result);
        else passed++;
        @(negedge Clock);
        ResetN = 1'b1;
        @(posedge Clock); #1;
        run_op64(64'h10, 64'h20, 1'b0, lat);
        checks++;
        if (lat !== 16 || result !== 64'h30 || cout !== 1'b0)
            $display("FAIL after_reset_op: lat=%0d result=%h cout=%b need 16/30/0",
                     lat, result, cout);
        else passed++;
        finish_op64();
    endtask

    task automatic test_back_to_back();
        int          acc_t[$];
        logic [64:0] got[2];
        int          nres;
        int          t;
        logic        acc;
        nres = 0;
        t    = 0;
        data_a    = 64'hFFFF_FFFF_FFFF_FFFF;
        data_b    = 64'd1;
        carry_in  = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while ((acc_t.size() < 2 || nres < 2) && t < 80) begin
            acc = in_valid && in_ready;
            @(posedge Clock); #1;
            t++;
            if (acc) begin
                acc_t.push_back(t);
                data_a = 64'd5;
                data_b = 64'd3;
                if (acc_t.size() == 2) in_valid = 1'b0;
            end
            if (out_valid && nres < 2) begin
                got[nres] = {cout, result};
                nres++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (out_valid) finish_op64();
        checks++;
        if (acc_t.size() != 2 || nres != 2)
            $display("FAIL b2b_progress: accepts=%0d results=%0d need 2/2", acc_t.size(), nres);
        else passed++;
        if (acc_t.size() == 2) begin
            checks++;
            if (acc_t[1] - acc_t[0] != 18)
                $display("FAIL b2b_interval: got %0d need 18", acc_t[1] - acc_t[0]);
            else passed++;
        end
        if (nres == 2) begin
            checks++;
            if (got[0] !== ref_sum(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0))
                $display("FAIL b2b_first: got %h need %h", got[0],
                         ref_sum(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0));
            else passed++;
            checks++;
            if (got[1] !== ref_sum(64'd5, 64'd3, 1'b0))
                $display("FAIL b2b_second: got %h need %h", got[1], ref_sum(64'd5, 64'd3, 1'b0));
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b;
        logic        c;
        logic [64:0] exp;
        int          lat;
        int          hold;
        for (int n = 0; n < 20; n++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            c   = 1'($urandom);
            exp = ref_sum(a, b, c);
            run_op64(a, b, c, lat);
            checks++;
            if (lat !== 16 || {cout, result} !== exp)
                $display("FAIL random%0d: lat=%0d got %b_%h need 16 %h", n, lat, cout, result,
                         exp);
            else passed++;
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
                @(posedge Clock); #1;
                checks++;
                if (out_valid !== 1'b1 || {cout, result} !== exp)
                    $display("FAIL random%0d_hold: valid=%b got %b_%h need 1 %h", n, out_valid,
                             cout, result, exp);
                else passed++;
            end
            finish_op64();
        end
    endtask

    task automatic test_width4();
        logic [3:0] a, b;
        logic       c;
        logic [4:0] exp;
        int         lat;
        for (int n = 0; n < 9; n++) begin
            if (n == 0) begin
                a = 4'hF; b = 4'h1; c = 1'b0;
            end else begin
                a = 4'($urandom); b = 4'($urandom); c = 1'($urandom);
            end
            exp  = {1'b0, a} + {1'b0, b} + {4'd0, c};
            a4   = a;
            b4   = b;
            cin4 = c;
            v4   = 1'b1;
            @(posedge Clock); #1;
            v4  = 1'b0;
            a4  = 4'($urandom);
            lat = 0;
            while (!ov4 && lat < 10) begin
                @(posedge Clock); #1;
                lat++;
            end
            checks++;
            if (lat !== 1 || {c4, res4} !== exp)
                $display("FAIL w4_op%0d: lat=%0d got %b_%h need 1 %h", n, lat, c4, res4, exp);
            else passed++;
            or4 = 1'b1;
            @(posedge Clock); #1;
            or4 = 1'b0;
            checks++;
            if (ov4 !== 1'b0 || r4_in_ready !== 1'b1)
                $display("FAIL w4_release%0d: valid=%b ready=%b need 0/1", n, ov4, r4_in_ready);
            else passed++;
        end
    endtask

    initial begin
        ResetN    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        carry_in  = 1'b0;
        data_a    = '0;
        data_b    = '0;
        v4        = 1'b0;
        or4       = 1'b0;
        cin4      = 1'b0;
        a4        = '0;
        b4        = '0;
        test_reset();
        test_full_carry();
        test_carry_chain();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_width4();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
